detector_feedback: RTL and testbench
====================================

# detector_feedback

Receive-side counterpart of the car command path: deserialises the simulator's UART detector frames and presents registered, validated obstacle flags to the car control logic. Runs on the board clock, checks framing and a sync nibble, and holds the last good detector state. If the link goes silent for too long, it forces all detectors to "blocked" so that motion logic fails safe.

## Interface
Parameters:
- CLKS_PER_BIT, default 10417, clock cycles per UART bit (100 MHz / 9600 baud); must be ≥ 4.
- TIMEOUT_CYCLES, default 10_000_000, cycles without a valid frame before the link is declared stale.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  UART line from the simulator, idle high, asynchronous to clk.
- front_detector  out  1  1 = obstacle ahead.
- left_detector  out  1  1 = obstacle to the left.
- right_detector  out  1  1 = obstacle to the right.
- back_detector  out  1  1 = obstacle behind.
- frame_valid  out  1  one-cycle pulse when a good frame updates the detectors.
- frame_error  out  1  one-cycle pulse when a bad stop bit or bad sync nibble causes a frame to be dropped.
- link_stale  out  1  1 while no valid frame has arrived within TIMEOUT_CYCLES.

## Operation
- rx passes through a 2-flop synchroniser before use. All decoding uses the synchronised signal rx_s.
- Line format is 8N1, LSB first.
- Byte layout:
  - bit0 = front, bit1 = left, bit2 = right, bit3 = back.
  - bits[7:4] must equal the sync nibble 4'b1010.
- Bit counting uses a timer that counts 0..CLKS_PER_BIT-1. A 3-bit counter tracks the data bit index.
- FSM states and transitions:
  - IDLE: on a falling edge of rx_s (previous 1, now 0), go to START and clear the timer.
  - START: after CLKS_PER_BIT/2 cycles (integer division), sample rx_s.
    - If the sample is 0, go to DATA.
    - If the sample is 1, treat it as a glitch and return to IDLE with no pulse.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[idx]. After idx 7 is sampled, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s, then return to IDLE in the same cycle.
    - If stop = 1 and shift[7:4] = 4'b1010: load the four detector registers from shift[3:0] and pulse frame_valid.
    - Otherwise: pulse frame_error and leave the detectors unchanged.
- Staleness counter:
  - Increments every cycle and saturates.
  - Clears to 0 on the frame_valid cycle.
  - When it reaches TIMEOUT_CYCLES-1, link_stale is set.
  - While link_stale = 1, all four detector outputs read 1, regardless of the stored values.
  - link_stale clears on the next frame_valid.
- Simultaneous frame_valid and timeout expiry: the valid frame wins. The counter clears and link_stale stays or becomes 0.
- A falling edge on rx_s during DATA or STOP is ignored. Only IDLE looks for start bits.

## Timing
- Reset values:
  - front/left/right/back_detector = 1.
  - link_stale = 1.
  - frame_valid = 0, frame_error = 0.
  - FSM = IDLE; timer and counters = 0; shift = 0.
- Synchroniser latency is 2 cycles from rx to rx_s.
- Each bit is sampled at its nominal midpoint: the start bit at CLKS_PER_BIT/2 after the edge, then every CLKS_PER_BIT.
- The detectors, frame_valid and frame_error all change on the clock edge that takes the stop sample. They are visible in the following cycle.
- frame_valid and frame_error are never both 1 and are never longer than one cycle.
- Return to IDLE happens at the stop-bit midpoint. A start bit immediately following the stop bit is therefore caught.
- Reset asserted mid-frame aborts the frame. All outputs return to their reset values asynchronously, and no pulse is emitted.
- The staleness counter width is $clog2(TIMEOUT_CYCLES+1).

## Structure
- Shared package car_sim_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - DET_SYNC = 4'b1010;
  - detector bit indices DET_FRONT = 0, DET_LEFT = 1, DET_RIGHT = 2, DET_BACK = 3.
- One sub-module, uart_rx_byte, covers the synchroniser, FSM and shift register. It outputs byte[7:0], byte_done and stop_ok.
- detector_feedback instantiates uart_rx_byte and adds the sync check, the detector registers and the staleness logic.

## Test plan
Bench parameters: CLKS_PER_BIT = 16, TIMEOUT_CYCLES = 2000.
- Reset, then rx idle high → detectors = 4'b1111, link_stale = 1, no pulses.
- Send byte 0xA5 with a valid stop bit → one frame_valid pulse; front = 1, left = 0, right = 1, back = 0; link_stale = 0.
- Send 0x55 (bad sync nibble) after a good frame → one frame_error pulse; detectors unchanged.
- Send 0xA0 with the stop bit driven 0 → frame_error pulse; detectors unchanged. Follow with 0xAF → frame_valid, detectors = 1111.
- Drive an rx low pulse of 4 cycles, then high → no pulse; FSM returns to IDLE; the next 0xA3 decodes correctly.
- After 0xA0, hold rx high for 2000 cycles → link_stale = 1 and detectors read 1111. Send 0xA0 → stale clears and detectors read 0000.

Source files
------------

// File: rtl/car_sim_pkg.sv
// car_sim_pkg: definitions shared by the car simulator link logic.
//   rx_state_e     : UART receive FSM states (IDLE, START, DATA, STOP)
//   DET_SYNC       : value required in the upper nibble of every detector byte
//   DET_FRONT..    : bit position of each detector flag in the byte
package car_sim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam logic [3:0] DET_SYNC = 4'b1010;

  localparam int DET_FRONT = 0;
  localparam int DET_LEFT  = 1;
  localparam int DET_RIGHT = 2;
  localparam int DET_BACK  = 3;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 LSB-first UART byte receiver.
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx         in   raw UART line (idle high, asynchronous to clk)
//   rx_byte    out  last assembled byte (shift register contents)
//   byte_done  out  high during the cycle whose clock edge takes the stop sample
//   stop_ok    out  value of the stop bit being sampled (valid with byte_done)
// rx is double-flopped into rx_s; every bit is sampled at its nominal midpoint.
module uart_rx_byte
  import car_sim_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       stop_ok
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  logic          rx_meta_reg;
  logic          rx_s_reg;
  logic          rx_prev_reg;
  rx_state_e     state_reg;
  logic [TW-1:0] timer_reg;
  logic [2:0]    idx_reg;
  logic [7:0]    shift_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_prev_reg <= 1'b1;
      state_reg   <= IDLE;
      timer_reg   <= '0;
      idx_reg     <= '0;
      shift_reg   <= '0;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
      rx_prev_reg <= rx_s_reg;
      case (state_reg)
        IDLE: begin
          // Only IDLE hunts for start bits; edges inside a frame are data.
          if (rx_prev_reg && !rx_s_reg) begin
            state_reg <= START;
            timer_reg <= '0;
          end
        end
        START: begin
          if (timer_reg == HALF_M1) begin
            timer_reg <= '0;
            idx_reg   <= '0;
            // Line already high again at mid start bit: a glitch, not a frame.
            state_reg <= rx_s_reg ? IDLE : DATA;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        DATA: begin
          if (timer_reg == FULL_M1) begin
            timer_reg          <= '0;
            shift_reg[idx_reg] <= rx_s_reg;
            idx_reg            <= idx_reg + 1'b1;
            if (idx_reg == 3'd7) state_reg <= STOP;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        STOP: begin
          // Leave at the stop midpoint so a start bit right after it is seen.
          if (timer_reg == FULL_M1) begin
            timer_reg <= '0;
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Decoded from registered state so the consumer can register its result
  // on the very edge that takes the stop sample.
  assign byte_done = (state_reg == STOP) && (timer_reg == FULL_M1);
  assign stop_ok   = rx_s_reg;
  assign rx_byte   = shift_reg;

endmodule

// File: rtl/detector_feedback.sv
// detector_feedback: receives detector frames from the simulator UART link.
//   clk              in   system clock
//   rst_n            in   asynchronous active-low reset
//   rx               in   UART line from the simulator (idle high)
//   front/left/right/back_detector  out  1 = obstacle (forced 1 while stale)
//   frame_valid      out  one-cycle pulse when a good frame updates detectors
//   frame_error      out  one-cycle pulse when a frame is dropped
//   link_stale       out  1 while no valid frame within TIMEOUT_CYCLES
module detector_feedback
  import car_sim_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 10417,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic front_detector,
  output logic left_detector,
  output logic right_detector,
  output logic back_detector,
  output logic frame_valid,
  output logic frame_error,
  output logic link_stale
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_M1 = CW'(TIMEOUT_CYCLES - 1);

  logic [7:0]    rx_byte;
  logic          byte_done;
  logic          stop_ok;
  logic          frame_good;
  logic          frame_bad;
  logic [3:0]    det_reg;
  logic [3:0]    det_out;
  logic          frame_valid_reg;
  logic          frame_error_reg;
  logic          link_stale_reg;
  logic [CW-1:0] stale_cnt_reg;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .byte_done(byte_done),
    .stop_ok  (stop_ok)
  );

  assign frame_good = byte_done && stop_ok && (rx_byte[7:4] == DET_SYNC);
  assign frame_bad  = byte_done && !frame_good;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_reg         <= 4'b1111;
      frame_valid_reg <= 1'b0;
      frame_error_reg <= 1'b0;
      link_stale_reg  <= 1'b1;
      stale_cnt_reg   <= '0;
    end else begin
      frame_valid_reg <= frame_good;
      frame_error_reg <= frame_bad;
      if (frame_good) det_reg <= rx_byte[3:0];
      // A valid frame takes priority over a coincident timeout.
      if (frame_good) begin
        stale_cnt_reg  <= '0;
        link_stale_reg <= 1'b0;
      end else if (stale_cnt_reg != TIMEOUT_M1) begin
        stale_cnt_reg <= stale_cnt_reg + 1'b1;
      end else begin
        link_stale_reg <= 1'b1;
      end
    end
  end

  // Stale link reads as "blocked everywhere" so motion logic stops.
  for (genvar gi = 0; gi < 4; gi++) begin : g_det
    assign det_out[gi] = det_reg[gi] | link_stale_reg;
  end

  assign front_detector = det_out[DET_FRONT];
  assign left_detector  = det_out[DET_LEFT];
  assign right_detector = det_out[DET_RIGHT];
  assign back_detector  = det_out[DET_BACK];
  assign frame_valid    = frame_valid_reg;
  assign frame_error    = frame_error_reg;
  assign link_stale     = link_stale_reg;

endmodule

// File: tb/tb_detector_feedback.sv
module tb_detector_feedback;

  localparam int CPB = 16;
  localparam int TMO = 2000;

  logic clk;
  logic rst_n;
  logic rx;
  logic front_detector, left_detector, right_detector, back_detector;
  logic frame_valid, frame_error, link_stale;
  logic [3:0] dets;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;
  int long_cnt = 0;
  int last_valid_cyc = -1;
  int stale_rise_cyc = -1;
  logic fv_prev = 1'b0;
  logic fe_prev = 1'b0;
  logic stale_prev = 1'b1;
  int v0, e0;

  detector_feedback #(
    .CLKS_PER_BIT  (CPB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .front_detector(front_detector),
    .left_detector (left_detector),
    .right_detector(right_detector),
    .back_detector (back_detector),
    .frame_valid   (frame_valid),
    .frame_error   (frame_error),
    .link_stale    (link_stale)
  );

  assign dets = {back_detector, right_detector, left_detector, front_detector};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (frame_error) err_cnt++;
    if (frame_valid && frame_error) overlap_cnt++;
    if ((frame_valid && fv_prev) || (frame_error && fe_prev)) long_cnt++;
    if (link_stale && !stale_prev) stale_rise_cyc = cyc;
    fv_prev    = frame_valid;
    fe_prev    = frame_error;
    stale_prev = link_stale;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
    rx = 1'b1;
    idle(gap);
  endtask

  initial begin
    rx = 1'b1;
    rst_n = 1'b0;
    idle(5);
    rst_n = 1'b1;
    idle(10);
    check("reset_dets", 32'(dets), 32'hF);
    check("reset_stale", 32'(link_stale), 32'd1);
    check("reset_valid", 32'(frame_valid), 32'd0);
    check("reset_error_cnt", 32'(err_cnt + valid_cnt), 32'd0);
    $display("txn reset dets=%h stale=%0b", dets, link_stale);

    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'hA5, 1'b1, 20);
    check("a5_valid", 32'(valid_cnt - v0), 32'd1);
    check("a5_error", 32'(err_cnt - e0), 32'd0);
    check("a5_dets", 32'(dets), 32'h5);
    check("a5_stale", 32'(link_stale), 32'd0);
    $display("txn 0xA5 dets=%h stale=%0b", dets, link_stale);

    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'h55, 1'b1, 20);
    check("badsync_error", 32'(err_cnt - e0), 32'd1);
    check("badsync_valid", 32'(valid_cnt - v0), 32'd0);
    check("badsync_dets", 32'(dets), 32'h5);
    $display("txn 0x55 dets=%h errors=%0d", dets, err_cnt);

    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'hA0, 1'b0, 20);
    check("badstop_error", 32'(err_cnt - e0), 32'd1);
    check("badstop_valid", 32'(valid_cnt - v0), 32'd0);
    check("badstop_dets", 32'(dets), 32'h5);
    $display("txn 0xA0/stop0 dets=%h errors=%0d", dets, err_cnt);

    v0 = valid_cnt;
    send_byte(8'hAF, 1'b1, 20);
    check("af_valid", 32'(valid_cnt - v0), 32'd1);
    check("af_dets", 32'(dets), 32'hF);
    check("af_stale", 32'(link_stale), 32'd0);
    $display("txn 0xAF dets=%h", dets);

    v0 = valid_cnt; e0 = err_cnt;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    check("glitch_pulses", 32'((valid_cnt - v0) + (err_cnt - e0)), 32'd0);
    $display("txn glitch pulses=%0d", (valid_cnt - v0) + (err_cnt - e0));

    v0 = valid_cnt;
    send_byte(8'hA3, 1'b1, 20);
    check("a3_valid", 32'(valid_cnt - v0), 32'd1);
    check("a3_dets", 32'(dets), 32'h3);
    $display("txn 0xA3 dets=%h", dets);

    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'hAC, 1'b1, 20);
    check("b2b_valid", 32'(valid_cnt - v0), 32'd2);
    check("b2b_error", 32'(err_cnt - e0), 32'd0);
    check("b2b_dets", 32'(dets), 32'hC);
    $display("txn 0xA5+0xAC back-to-back dets=%h", dets);

    send_byte(8'hA0, 1'b1, 20);
    check("a0_dets", 32'(dets), 32'h0);
    idle(TMO + 50);
    check("timeout_stale", 32'(link_stale), 32'd1);
    check("timeout_dets", 32'(dets), 32'hF);
    check("timeout_latency", 32'(stale_rise_cyc - last_valid_cyc), 32'(TMO));
    $display("txn timeout stale=%0b dets=%h latency=%0d", link_stale, dets,
             stale_rise_cyc - last_valid_cyc);

    send_byte(8'hA0, 1'b1, 20);
    check("recover_stale", 32'(link_stale), 32'd0);
    check("recover_dets", 32'(dets), 32'h0);
    $display("txn 0xA0 recover stale=%0b dets=%h", link_stale, dets);

    v0 = valid_cnt; e0 = err_cnt;
    rx = 1'b0;
    idle(40);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dets", 32'(dets), 32'hF);
    check("midrst_stale", 32'(link_stale), 32'd1);
    check("midrst_valid", 32'(frame_valid), 32'd0);
    rx = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(200);
    check("midrst_pulses", 32'((valid_cnt - v0) + (err_cnt - e0)), 32'd0);
    $display("txn reset mid-frame dets=%h stale=%0b", dets, link_stale);

    check("pulse_overlap", 32'(overlap_cnt), 32'd0);
    check("pulse_width", 32'(long_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
